framebuffer_arbiter: RTL and testbench

//  Shares the single-port framebuffer SRAM between the MCU pixel stream and the display scanout.
//  MCU pixels (12-bit RGB from the bus decoder) enter a small write FIFO and receive auto-incrementing addresses.

---
 rtl/framebuffer_arbiter_if.sv | 39 +++
 rtl/framebuffer_arbiter.sv | 154 +++++++++++++++
 tb/tb_framebuffer_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/framebuffer_arbiter_if.sv
// Bus bundle between the framebuffer arbiter and its clients: MCU pixel path,
// display scanout and the external single-port SRAM pins.
interface framebuffer_arbiter_if #(
    parameter int ADDRESS_WIDTH = 19,
    parameter int PIXEL_WIDTH   = 12
);
    logic                     pixel_write_strobe;
    logic [PIXEL_WIDTH-1:0]   pixel_data;
    logic                     set_address_strobe;
    logic [ADDRESS_WIDTH-1:0] set_address;
    logic                     write_fifo_full;
    logic                     write_overflow;
    logic                     display_read_request;
    logic [ADDRESS_WIDTH-1:0] display_read_address;
    logic [PIXEL_WIDTH-1:0]   display_read_data;
    logic                     display_read_valid;
    logic [ADDRESS_WIDTH-1:0] sram_address;
    logic [PIXEL_WIDTH-1:0]   sram_data_out;
    logic [PIXEL_WIDTH-1:0]   sram_data_in;
    logic                     sram_write_enable;
    logic                     sram_output_enable;
    logic                     busy;

    // Arbiter side.
    modport slave (
        input  pixel_write_strobe, pixel_data, set_address_strobe, set_address,
               display_read_request, display_read_address, sram_data_in,
        output write_fifo_full, write_overflow, display_read_data, display_read_valid,
               sram_address, sram_data_out, sram_write_enable, sram_output_enable, busy
    );

    // Client side: MCU, scanout and SRAM.
    modport master (
        output pixel_write_strobe, pixel_data, set_address_strobe, set_address,
               display_read_request, display_read_address, sram_data_in,
        input  write_fifo_full, write_overflow, display_read_data, display_read_valid,
               sram_address, sram_data_out, sram_write_enable, sram_output_enable, busy
    );
endinterface

// File: rtl/framebuffer_arbiter.sv
// Shares one single-port framebuffer SRAM between queued MCU pixel writes and
// display scanout reads; reads win, with a starvation guard so writes drain.
module framebuffer_arbiter #(
    parameter int ADDRESS_WIDTH = 19,
    parameter int PIXEL_WIDTH   = 12,
    parameter int FIFO_DEPTH    = 4,
    parameter int FRAME_PIXELS  = 307200,
    parameter int STARVE_LIMIT  = 8
) (
    input  logic                  system_clock,
    input  logic                  reset,
    framebuffer_arbiter_if.slave  bus
);
    localparam int PTR_WIDTH    = $clog2(FIFO_DEPTH);
    localparam int STARVE_WIDTH = $clog2(STARVE_LIMIT + 1);
    localparam logic [PTR_WIDTH:0]        FULL_COUNT = (PTR_WIDTH + 1)'(FIFO_DEPTH);
    localparam logic [STARVE_WIDTH-1:0]   STARVE_MAX = STARVE_WIDTH'(STARVE_LIMIT);
    localparam logic [ADDRESS_WIDTH-1:0]  FRAME_LAST = ADDRESS_WIDTH'(FRAME_PIXELS - 1);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_SETUP, WR_STROBE} state_t;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] address;
        logic [PIXEL_WIDTH-1:0]   pixel;
    } fifo_entry_t;

    state_t                    state;
    logic [STARVE_WIDTH-1:0]   starve_count;
    logic [ADDRESS_WIDTH-1:0]  write_pointer;
    logic [PTR_WIDTH-1:0]      fifo_write_index;
    logic [PTR_WIDTH-1:0]      fifo_read_index;
    logic [PTR_WIDTH:0]        fifo_count;
    fifo_entry_t               fifo_mem [FIFO_DEPTH];

    logic [ADDRESS_WIDTH-1:0]  sram_address;
    logic [PIXEL_WIDTH-1:0]    sram_data_out;
    logic                      sram_write_enable;
    logic                      sram_output_enable;
    logic [PIXEL_WIDTH-1:0]    display_read_data;
    logic                      display_read_valid;
    logic                      busy;
    logic                      write_overflow;

    logic                      fifo_empty;
    logic                      fifo_full;
    logic                      pop;
    logic                      push;
    logic [ADDRESS_WIDTH-1:0]  push_address;
    logic [ADDRESS_WIDTH-1:0]  next_pointer;
    fifo_entry_t               fifo_head;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == FULL_COUNT);
    assign pop        = (state == WR_STROBE);
    // A full FIFO still accepts a pixel in the cycle its head is being popped.
    assign push       = bus.pixel_write_strobe && (!fifo_full || pop);
    assign push_address = bus.set_address_strobe ? bus.set_address : write_pointer;
    assign next_pointer = (push_address == FRAME_LAST) ? '0 : push_address + 1'b1;
    assign fifo_head    = fifo_mem[fifo_read_index];

    always_ff @(posedge system_clock) begin
        if (reset) begin
            write_pointer    <= '0;
            fifo_write_index <= '0;
            fifo_read_index  <= '0;
            fifo_count       <= '0;
            write_overflow   <= 1'b0;
        end else begin
            if (push) begin
                write_pointer    <= next_pointer;
                fifo_write_index <= fifo_write_index + 1'b1;
            end else if (bus.set_address_strobe) begin
                write_pointer <= bus.set_address;
            end
            if (pop)
                fifo_read_index <= fifo_read_index + 1'b1;
            if (push && !pop)
                fifo_count <= fifo_count + 1'b1;
            else if (pop && !push)
                fifo_count <= fifo_count - 1'b1;
            if (bus.pixel_write_strobe && !push)
                write_overflow <= 1'b1;
        end
    end

    // NOTE: FIFO storage has no reset; the count/index registers define which entries are live.
    always_ff @(posedge system_clock) begin
        if (push)
            fifo_mem[fifo_write_index] <= '{address: push_address, pixel: bus.pixel_data};
    end

    always_ff @(posedge system_clock) begin
        if (reset) begin
            state              <= IDLE;
            starve_count       <= '0;
            sram_address       <= '0;
            sram_data_out      <= '0;
            sram_write_enable  <= 1'b0;
            sram_output_enable <= 1'b0;
            display_read_data  <= '0;
            display_read_valid <= 1'b0;
            busy               <= 1'b0;
        end else begin
            display_read_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.display_read_request && (fifo_empty || starve_count < STARVE_MAX)) begin
                        state              <= RD_ADDR;
                        sram_address       <= bus.display_read_address;
                        sram_output_enable <= 1'b1;
                        busy               <= 1'b1;
                        starve_count       <= fifo_empty ? '0 : starve_count + 1'b1;
                    end else if (!fifo_empty) begin
                        state         <= WR_SETUP;
                        sram_address  <= fifo_head.address;
                        sram_data_out <= fifo_head.pixel;
                        busy          <= 1'b1;
                        starve_count  <= '0;
                    end else begin
                        starve_count <= '0;
                    end
                end
                RD_ADDR: state <= RD_DATA;
                RD_DATA: begin
                    display_read_data  <= bus.sram_data_in;
                    display_read_valid <= 1'b1;
                    sram_output_enable <= 1'b0;
                    busy               <= 1'b0;
                    state              <= IDLE;
                end
                WR_SETUP: begin
                    sram_write_enable <= 1'b1;
                    state             <= WR_STROBE;
                end
                WR_STROBE: begin
                    sram_write_enable <= 1'b0;
                    busy              <= 1'b0;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.write_fifo_full    = fifo_full;
    assign bus.write_overflow     = write_overflow;
    assign bus.display_read_data  = display_read_data;
    assign bus.display_read_valid = display_read_valid;
    assign bus.sram_address       = sram_address;
    assign bus.sram_data_out      = sram_data_out;
    assign bus.sram_write_enable  = sram_write_enable;
    assign bus.sram_output_enable = sram_output_enable;
    assign bus.busy               = busy;
endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Directed bench for framebuffer_arbiter with a behavioural SRAM model and an
// access log of SRAM writes and read starts.
module tb_framebuffer_arbiter;
    logic system_clock;
    logic reset;

    framebuffer_arbiter_if #(.ADDRESS_WIDTH(19), .PIXEL_WIDTH(12)) bus ();

    framebuffer_arbiter dut (
        .system_clock (system_clock),
        .reset        (reset),
        .bus          (bus.slave)
    );

    initial system_clock = 1'b0;
    always #5 system_clock = ~system_clock;

    int checks = 0;
    int errors = 0;

    logic [11:0] mem [int];
    int          wr_addr_q [$];
    int          wr_data_q [$];
    logic [7:0]  seq_q [$];
    int          we_count = 0;
    int          overlap_count = 0;
    logic        prev_oe = 1'b0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // SRAM model and access log, sampled on the inactive edge.
    always @(negedge system_clock) begin
        if (bus.sram_write_enable) begin
            wr_addr_q.push_back(32'(bus.sram_address));
            wr_data_q.push_back(32'(bus.sram_data_out));
            mem[int'(bus.sram_address)] = bus.sram_data_out;
            we_count++;
            seq_q.push_back("W");
        end
        if (bus.sram_output_enable && !prev_oe)
            seq_q.push_back("R");
        if (bus.sram_output_enable && bus.sram_write_enable)
            overlap_count++;
        prev_oe = bus.sram_output_enable;
        if (bus.sram_output_enable && mem.exists(int'(bus.sram_address)))
            bus.sram_data_in = mem[int'(bus.sram_address)];
        else
            bus.sram_data_in = 12'h000;
    end

    task automatic step();
        @(posedge system_clock);
        #1;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        seq_q.delete();
        we_count = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.pixel_write_strobe   = 1'b0;
        bus.pixel_data           = '0;
        bus.set_address_strobe   = 1'b0;
        bus.set_address          = '0;
        bus.display_read_request = 1'b0;
        bus.display_read_address = '0;
        repeat (2) step();
        reset = 1'b0;
        clear_log();
    endtask

    task automatic push_pixel(input logic [11:0] pixel);
        bus.pixel_write_strobe = 1'b1;
        bus.pixel_data         = pixel;
        step();
        bus.pixel_write_strobe = 1'b0;
    endtask

    task automatic set_addr(input logic [18:0] address);
        bus.set_address_strobe = 1'b1;
        bus.set_address        = address;
        step();
        bus.set_address_strobe = 1'b0;
    endtask

    task automatic wait_writes(input string tag, input int n, input int budget);
        int i = 0;
        while (we_count < n && i < budget) begin
            step();
            i++;
        end
        check(tag, 32'(we_count >= n), 32'd1);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset state, then three sequential writes from address 100
        do_reset();
        check("rst_busy",     32'(bus.busy), 0);
        check("rst_we",       32'(bus.sram_write_enable), 0);
        check("rst_oe",       32'(bus.sram_output_enable), 0);
        check("rst_full",     32'(bus.write_fifo_full), 0);
        check("rst_overflow", 32'(bus.write_overflow), 0);
        check("rst_valid",    32'(bus.display_read_valid), 0);
        check("rst_addr",     32'(bus.sram_address), 0);
        set_addr(19'd100);
        push_pixel(12'hF00);
        push_pixel(12'h0F0);
        push_pixel(12'h00F);
        wait_writes("t1_done", 3, 40);
        repeat (10) step();
        check("t1_we_count", 32'(we_count), 3);
        check("t1_addr0", 32'(wr_addr_q[0]), 100);
        check("t1_addr1", 32'(wr_addr_q[1]), 101);
        check("t1_addr2", 32'(wr_addr_q[2]), 102);
        check("t1_data0", 32'(wr_data_q[0]), 32'hF00);
        check("t1_data1", 32'(wr_data_q[1]), 32'h0F0);
        check("t1_data2", 32'(wr_data_q[2]), 32'h00F);

        // 2: single read, valid three cycles after the request is seen
        do_reset();
        mem[32'h1234] = 12'hABC;
        bus.display_read_request = 1'b1;
        bus.display_read_address = 19'h01234;
        begin
            int latency = 0;
            for (int n = 1; n <= 10; n++) begin
                step();
                if (n == 1) begin
                    check("t2_rd_addr", 32'(bus.sram_address), 32'h1234);
                    check("t2_rd_oe",   32'(bus.sram_output_enable), 1);
                end
                if (bus.display_read_valid) begin
                    latency = n;
                    break;
                end
            end
            check("t2_latency", 32'(latency), 3);
        end
        check("t2_data", 32'(bus.display_read_data), 32'hABC);
        bus.display_read_request = 1'b0;
        step();
        check("t2_valid_once", 32'(bus.display_read_valid), 0);
        check("t2_idle", 32'(bus.busy), 0);

        // 3: continuous reads with one pending pixel -> 8 reads, 1 write, reads resume
        do_reset();
        bus.display_read_request = 1'b1;
        bus.display_read_address = 19'h00010;
        step();
        check("t3_first_read", 32'(bus.sram_output_enable), 1);
        push_pixel(12'h0AA);
        seq_q.delete();
        repeat (45) step();
        begin
            int lead = 0;
            while (lead < seq_q.size() && seq_q[lead] == "R")
                lead++;
            check("t3_reads_before_write", 32'(lead), 8);
            check("t3_write_slot", 32'(seq_q.size() > 9 && seq_q[8] == "W"), 1);
            check("t3_reads_resume", 32'(seq_q.size() > 9 && seq_q[9] == "R"), 1);
        end
        check("t3_write_addr", 32'(wr_addr_q.size() > 0 ? wr_addr_q[0] : -1), 0);
        bus.display_read_request = 1'b0;
        repeat (5) step();

        // 4: six pushes while reads hog the bus -> full after four, overflow
        do_reset();
        bus.display_read_request = 1'b1;
        bus.display_read_address = 19'h00020;
        step();
        for (int i = 1; i <= 4; i++)
            push_pixel(12'(12'h100 + i));
        check("t4_full", 32'(bus.write_fifo_full), 1);
        check("t4_no_overflow_yet", 32'(bus.write_overflow), 0);
        push_pixel(12'h105);
        push_pixel(12'h106);
        check("t4_overflow", 32'(bus.write_overflow), 1);
        check("t4_no_writes_yet", 32'(we_count), 0);
        bus.display_read_request = 1'b0;
        wait_writes("t4_done", 4, 60);
        repeat (15) step();
        check("t4_we_count", 32'(we_count), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4_addr%0d", i), 32'(wr_addr_q[i]), 32'(i));
            check($sformatf("t4_data%0d", i), 32'(wr_data_q[i]), 32'(12'h101 + i));
        end
        check("t4_overflow_sticky", 32'(bus.write_overflow), 1);
        check("t4_drained", 32'(bus.write_fifo_full), 0);

        // 5: write pointer wraps at the last frame pixel
        do_reset();
        set_addr(19'd307199);
        push_pixel(12'h111);
        push_pixel(12'h222);
        wait_writes("t5_done", 2, 30);
        check("t5_addr0", 32'(wr_addr_q[0]), 307199);
        check("t5_addr1", 32'(wr_addr_q[1]), 0);
        check("t5_data1", 32'(wr_data_q[1]), 32'h222);

        // 6: set address and push in the same cycle
        do_reset();
        bus.set_address_strobe = 1'b1;
        bus.set_address        = 19'd50;
        push_pixel(12'h333);
        bus.set_address_strobe = 1'b0;
        push_pixel(12'h444);
        wait_writes("t6_done", 2, 30);
        check("t6_addr0", 32'(wr_addr_q[0]), 50);
        check("t6_addr1", 32'(wr_addr_q[1]), 51);
        check("t6_data0", 32'(wr_data_q[0]), 32'h333);

        // 7: reset during WR_STROBE aborts and discards the queue
        do_reset();
        push_pixel(12'h555);
        push_pixel(12'h666);
        push_pixel(12'h777);
        begin
            int i = 0;
            while (!bus.sram_write_enable && i < 20) begin
                step();
                i++;
            end
            check("t7_in_strobe", 32'(bus.sram_write_enable), 1);
        end
        reset = 1'b1;
        step();
        check("t7_we", 32'(bus.sram_write_enable), 0);
        check("t7_busy", 32'(bus.busy), 0);
        check("t7_full", 32'(bus.write_fifo_full), 0);
        reset = 1'b0;
        clear_log();
        push_pixel(12'h888);
        wait_writes("t7_done", 1, 20);
        repeat (10) step();
        check("t7_we_count", 32'(we_count), 1);
        check("t7_ptr_zero", 32'(wr_addr_q[0]), 0);
        check("t7_data", 32'(wr_data_q[0]), 32'h888);

        check("oe_we_exclusive", 32'(overlap_count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
